// File: rtl/instr_issuer_if.sv
// Command/data/instruction bundle between the host and the instruction issuer.
// The master modport is the host side; the slave modport is the issuer.
interface instr_issuer_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_op;
  logic [15:0] cmd_addr;
  logic [7:0]  cmd_count;
  logic [31:0] data_in;
  logic        data_valid;
  logic        data_ready;
  logic [63:0] instruction;
  logic        busy;
  logic        done;
  logic        cmd_err;

  modport master (
    output cmd_valid, cmd_op, cmd_addr, cmd_count, data_in, data_valid,
    input  cmd_ready, data_ready, instruction, busy, done, cmd_err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_addr, cmd_count, data_in, data_valid,
    output cmd_ready, data_ready, instruction, busy, done, cmd_err
  );
endinterface

// File: rtl/instr_issuer.sv
// Host-side sequencer: expands host commands into the 64-bit instruction stream
// {11'b0, data, addr, opcode}, one word per cycle, with NOP gaps after MAC/SEND_WT.
module instr_issuer #(
  parameter int MAC_WAIT     = 16,
  parameter int SEND_WT_WAIT = 8,
  parameter int BUF_ADDR_W   = 7,
  parameter int OUT_ADDR_W   = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  instr_issuer_if.slave bus
);

  localparam int AW = (BUF_ADDR_W > OUT_ADDR_W) ? BUF_ADDR_W : OUT_ADDR_W;

  localparam logic [2:0] CMD_LOAD_INP  = 3'd0;
  localparam logic [2:0] CMD_LOAD_WT   = 3'd1;
  localparam logic [2:0] CMD_SEND_WT   = 3'd2;
  localparam logic [2:0] CMD_MAC       = 3'd3;
  localparam logic [2:0] CMD_STORE     = 3'd4;
  localparam logic [2:0] CMD_TRANSMIT  = 3'd5;
  localparam logic [2:0] CMD_ILLEGAL   = 3'd7;

  localparam logic [4:0] OP_MAC       = 5'b00001;
  localparam logic [4:0] OP_SEND_WT   = 5'b00010;
  localparam logic [4:0] OP_STORE     = 5'b00011;
  localparam logic [4:0] OP_RECV_INP  = 5'b00100;
  localparam logic [4:0] OP_RECV_WT   = 5'b00101;
  localparam logic [4:0] OP_TRANSMIT  = 5'b00110;
  localparam logic [4:0] OP_RESET_ACC = 5'b00111;
  localparam logic [4:0] OP_NOP       = 5'b11111;

  typedef enum logic [2:0] {IDLE, LOAD, XMIT, SINGLE, WAIT} state_e;

  state_e          state_q, state_d;
  logic [2:0]      op_q, op_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [7:0]      count_q, count_d;
  logic [7:0]      idx_q, idx_d;
  logic [7:0]      wait_q, wait_d;
  logic [63:0]     instr_q, instr_d;
  logic            done_q, done_d;
  logic            err_q, err_d;

  logic                  lastIdx;
  logic [BUF_ADDR_W-1:0] bufAddr;
  logic [OUT_ADDR_W-1:0] outAddr;

  function automatic logic [63:0] mkInstr(input logic [31:0] d, input logic [15:0] a,
                                          input logic [4:0] o);
    return {11'b0, d, a, o};
  endfunction

  assign lastIdx = (idx_q == (count_q - 8'd1));
  assign bufAddr = addr_q[BUF_ADDR_W-1:0] + BUF_ADDR_W'(idx_q);
  assign outAddr = addr_q[OUT_ADDR_W-1:0] + OUT_ADDR_W'(idx_q);

  // Idle/bubble cycles fall through with instr_d = 0 so a stale word is never held.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    addr_d  = addr_q;
    count_d = count_q;
    idx_d   = idx_q;
    wait_d  = wait_q;
    instr_d = '0;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.cmd_valid) begin
          op_d    = bus.cmd_op;
          addr_d  = bus.cmd_addr[AW-1:0];
          count_d = bus.cmd_count;
          idx_d   = 8'd0;
          case (bus.cmd_op)
            CMD_LOAD_INP, CMD_LOAD_WT, CMD_TRANSMIT: begin
              if (bus.cmd_count == 8'd0) done_d = 1'b1;
              else state_d = (bus.cmd_op == CMD_TRANSMIT) ? XMIT : LOAD;
            end
            CMD_ILLEGAL: begin
              done_d = 1'b1;
              err_d  = 1'b1;
            end
            default: state_d = SINGLE;
          endcase
        end
      end
      LOAD: begin
        if (bus.data_valid) begin
          instr_d = mkInstr(bus.data_in, 16'(bufAddr),
                            (op_q == CMD_LOAD_WT) ? OP_RECV_WT : OP_RECV_INP);
          idx_d   = idx_q + 8'd1;
          if (lastIdx) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      XMIT: begin
        instr_d = mkInstr(32'd0, 16'(outAddr), OP_TRANSMIT);
        idx_d   = idx_q + 8'd1;
        if (lastIdx) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      SINGLE: begin
        case (op_q)
          CMD_MAC: begin
            instr_d = mkInstr(32'd0, 16'd0, OP_MAC);
            wait_d  = 8'(MAC_WAIT - 1);
            state_d = WAIT;
          end
          CMD_SEND_WT: begin
            instr_d = mkInstr(32'd0, 16'd0, OP_SEND_WT);
            wait_d  = 8'(SEND_WT_WAIT - 1);
            state_d = WAIT;
          end
          CMD_STORE: begin
            instr_d = mkInstr(32'd0, 16'(addr_q[OUT_ADDR_W-1:0]), OP_STORE);
            state_d = IDLE;
            done_d  = 1'b1;
          end
          default: begin
            instr_d = mkInstr(32'd0, 16'd0, OP_RESET_ACC);
            state_d = IDLE;
            done_d  = 1'b1;
          end
        endcase
      end
      WAIT: begin
        instr_d = mkInstr(32'd0, 16'd0, OP_NOP);
        if (wait_q == 8'd0) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          wait_d = wait_q - 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_q    <= '0;
      addr_q  <= '0;
      count_q <= '0;
      idx_q   <= '0;
      wait_q  <= '0;
      instr_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      count_q <= count_d;
      idx_q   <= idx_d;
      wait_q  <= wait_d;
      instr_q <= instr_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign bus.cmd_ready   = (state_q == IDLE);
  assign bus.data_ready  = (state_q == LOAD);
  assign bus.busy        = (state_q != IDLE);
  assign bus.instruction = instr_q;
  assign bus.done        = done_q;
  assign bus.cmd_err     = err_q;

endmodule

// File: tb/tb_instr_issuer.sv
// Directed self-checking bench for instr_issuer; expected words are hand-built
// from the {11'b0, data, addr, opcode} instruction layout.
module tb_instr_issuer;

  logic clk;
  logic rst_n;
  int   assertCount = 0;
  int   failCount   = 0;
  int   readyLow;

  instr_issuer_if bus ();

  instr_issuer #(
    .MAC_WAIT(16), .SEND_WT_WAIT(8), .BUF_ADDR_W(7), .OUT_ADDR_W(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [63:0] mk(input logic [31:0] d, input logic [15:0] a,
                                     input logic [4:0] o);
    return {11'b0, d, a, o};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    assertCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] expInstr,
                             input logic expDone, input logic expErr, input logic expBusy);
    checkVal({tag, ".instr"}, bus.instruction, expInstr);
    checkVal({tag, ".done"}, 64'(bus.done), 64'(expDone));
    checkVal({tag, ".err"}, 64'(bus.cmd_err), 64'(expErr));
    checkVal({tag, ".busy"}, 64'(bus.busy), 64'(expBusy));
  endtask

  // Present one command and let the issuer accept it on the next edge.
  task automatic applyStimulus(input logic [2:0] op, input logic [15:0] addr,
                               input logic [7:0] count);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_addr  = addr;
    bus.cmd_count = count;
    tick();
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 3'd0;
    bus.cmd_addr  = 16'd0;
    bus.cmd_count = 8'd0;
  endtask

  initial begin
    bus.cmd_valid  = 1'b0;
    bus.cmd_op     = 3'd0;
    bus.cmd_addr   = 16'd0;
    bus.cmd_count  = 8'd0;
    bus.data_in    = 32'd0;
    bus.data_valid = 1'b0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    checkOutput("reset", 64'd0, 1'b0, 1'b0, 1'b0);
    checkVal("reset.cmd_ready", 64'(bus.cmd_ready), 64'd1);
    checkVal("reset.data_ready", 64'(bus.data_ready), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    checkOutput("postreset", 64'd0, 1'b0, 1'b0, 1'b0);

    // LOAD_INP wrapping at the 7-bit buffer address boundary.
    applyStimulus(3'd0, 16'h007E, 8'd3);
    checkOutput("loadinp.accept", 64'd0, 1'b0, 1'b0, 1'b1);
    checkVal("loadinp.data_ready", 64'(bus.data_ready), 64'd1);
    checkVal("loadinp.cmd_ready", 64'(bus.cmd_ready), 64'd0);
    bus.data_valid = 1'b1;
    bus.data_in = 32'hAAAA_0001;
    tick();
    checkOutput("loadinp.w0", mk(32'hAAAA_0001, 16'h007E, 5'b00100), 1'b0, 1'b0, 1'b1);
    bus.data_in = 32'hBBBB_0002;
    tick();
    checkOutput("loadinp.w1", mk(32'hBBBB_0002, 16'h007F, 5'b00100), 1'b0, 1'b0, 1'b1);
    bus.data_in = 32'hCCCC_0003;
    tick();
    checkOutput("loadinp.w2", mk(32'hCCCC_0003, 16'h0000, 5'b00100), 1'b1, 1'b0, 1'b0);
    bus.data_valid = 1'b0;
    bus.data_in = 32'd0;
    tick();
    checkOutput("loadinp.after", 64'd0, 1'b0, 1'b0, 1'b0);

    // LOAD_WT with a two-cycle data stall between words.
    applyStimulus(3'd1, 16'h0010, 8'd2);
    bus.data_valid = 1'b1;
    bus.data_in = 32'h1234_5678;
    tick();
    checkOutput("loadwt.w0", mk(32'h1234_5678, 16'h0010, 5'b00101), 1'b0, 1'b0, 1'b1);
    bus.data_valid = 1'b0;
    tick();
    checkOutput("loadwt.bubble0", 64'd0, 1'b0, 1'b0, 1'b1);
    tick();
    checkOutput("loadwt.bubble1", 64'd0, 1'b0, 1'b0, 1'b1);
    bus.data_valid = 1'b1;
    bus.data_in = 32'h9ABC_DEF0;
    tick();
    checkOutput("loadwt.w1", mk(32'h9ABC_DEF0, 16'h0011, 5'b00101), 1'b1, 1'b0, 1'b0);
    bus.data_valid = 1'b0;
    tick();
    checkOutput("loadwt.after", 64'd0, 1'b0, 1'b0, 1'b0);

    // MAC followed by 16 NOPs; cmd_ready must stay low for 17 cycles.
    applyStimulus(3'd3, 16'h0055, 8'd0);
    readyLow = 0;
    if (!bus.cmd_ready) readyLow++;
    tick();
    checkOutput("mac.instr", 64'h1, 1'b0, 1'b0, 1'b1);
    if (!bus.cmd_ready) readyLow++;
    for (int i = 0; i < 16; i++) begin
      tick();
      checkOutput($sformatf("mac.nop%0d", i), 64'h1F, (i == 15), 1'b0, (i != 15));
      if (!bus.cmd_ready) readyLow++;
    end
    checkVal("mac.readyLowCycles", 64'(readyLow), 64'd17);
    tick();
    checkOutput("mac.after", 64'd0, 1'b0, 1'b0, 1'b0);

    // TRANSMIT wrapping at the 4-bit output address boundary.
    applyStimulus(3'd5, 16'h000E, 8'd4);
    tick();
    checkOutput("xmit.0", mk(32'd0, 16'h000E, 5'b00110), 1'b0, 1'b0, 1'b1);
    tick();
    checkOutput("xmit.1", mk(32'd0, 16'h000F, 5'b00110), 1'b0, 1'b0, 1'b1);
    tick();
    checkOutput("xmit.2", mk(32'd0, 16'h0000, 5'b00110), 1'b0, 1'b0, 1'b1);
    tick();
    checkOutput("xmit.3", mk(32'd0, 16'h0001, 5'b00110), 1'b1, 1'b0, 1'b0);
    tick();
    checkOutput("xmit.after", 64'd0, 1'b0, 1'b0, 1'b0);

    applyStimulus(3'd7, 16'h0003, 8'd5);
    checkOutput("illegal", 64'd0, 1'b1, 1'b1, 1'b0);
    checkVal("illegal.cmd_ready", 64'(bus.cmd_ready), 64'd1);
    tick();
    checkOutput("illegal.after", 64'd0, 1'b0, 1'b0, 1'b0);

    applyStimulus(3'd0, 16'h0040, 8'd0);
    checkOutput("zerocount", 64'd0, 1'b1, 1'b0, 1'b0);
    tick();
    checkOutput("zerocount.after", 64'd0, 1'b0, 1'b0, 1'b0);

    // Singles: STORE keeps only the low output-address bits.
    applyStimulus(3'd4, 16'h1234, 8'd0);
    tick();
    checkOutput("store", mk(32'd0, 16'h0004, 5'b00011), 1'b1, 1'b0, 1'b0);
    applyStimulus(3'd6, 16'h00FF, 8'd0);
    tick();
    checkOutput("resetacc", mk(32'd0, 16'h0000, 5'b00111), 1'b1, 1'b0, 1'b0);
    applyStimulus(3'd2, 16'h0077, 8'd0);
    tick();
    checkOutput("sendwt.instr", 64'h2, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      tick();
      checkOutput($sformatf("sendwt.nop%0d", i), 64'h1F, (i == 7), 1'b0, (i != 7));
    end
    tick();
    checkOutput("sendwt.after", 64'd0, 1'b0, 1'b0, 1'b0);

    // Reset mid-LOAD abandons the burst; a fresh command must then be accepted.
    applyStimulus(3'd0, 16'h0020, 8'd5);
    bus.data_valid = 1'b1;
    bus.data_in = 32'h0000_00A0;
    tick();
    checkOutput("rstload.w0", mk(32'h0000_00A0, 16'h0020, 5'b00100), 1'b0, 1'b0, 1'b1);
    bus.data_in = 32'h0000_00A1;
    tick();
    checkOutput("rstload.w1", mk(32'h0000_00A1, 16'h0021, 5'b00100), 1'b0, 1'b0, 1'b1);
    bus.data_in = 32'h0000_00A2;
    rst_n = 1'b0;
    #1;
    checkOutput("rstload.inreset", 64'd0, 1'b0, 1'b0, 1'b0);
    checkVal("rstload.cmd_ready", 64'(bus.cmd_ready), 64'd1);
    @(posedge clk);
    #1 rst_n = 1'b1;
    bus.data_valid = 1'b0;
    bus.data_in = 32'd0;
    tick();
    checkOutput("rstload.released", 64'd0, 1'b0, 1'b0, 1'b0);
    applyStimulus(3'd5, 16'h0003, 8'd1);
    checkOutput("rstload.newaccept", 64'd0, 1'b0, 1'b0, 1'b1);
    tick();
    checkOutput("rstload.newxmit", mk(32'd0, 16'h0003, 5'b00110), 1'b1, 1'b0, 1'b0);
    tick();
    checkOutput("rstload.idle", 64'd0, 1'b0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
